// File: rtl/fixed_point_log.sv
//-----------------------------------------------------------------------------
// fixed_point_log
//
// Sequential natural logarithm for Q16.16 sign-magnitude operands.
// ln(x) = log2(x) * ln2. The integer part of log2 comes from the position of
// the leading one. The fraction comes from repeated squaring of the
// normalised mantissa, which yields one log2 bit per ITER cycle.
//
// Handshake: start is sampled only while idle (busy low). The operand is
// latched on that edge. done pulses for one cycle when out/err carry the new
// result, and both hold that value until the next done. A start seen while
// busy is dropped. There is no queueing.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   start  operation request
//   x      operand, sign-magnitude Q16.16
//   busy   high in every state except IDLE
//   done   one-cycle result-valid pulse
//   out    ln(x), sign-magnitude Q16.16
//   err    domain error (x == 0 or x < 0), valid with done
//
// Optional build macro FIXED_LOG_ROUND_EN: computes one extra guard bit of
// log2 (one more ITER cycle) and rounds the final ln2 product to nearest.
// Without the macro the product is truncated.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module fixed_point_log #(
    parameter int N         = 32,
    parameter int Q         = 16,
    parameter int FRAC_BITS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] x,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] out,
    output logic         err
);

`ifdef FIXED_LOG_ROUND_EN
    localparam int G = 1;              // guard bits kept in acc
`else
    localparam int G = 0;
`endif
    localparam int ITERS = FRAC_BITS + G;
    localparam int MW    = 2*Q + 2;    // mantissa working width
    localparam int AW    = N + 1 + G;  // log2 accumulator, Q+G fraction bits
    localparam int PW    = $clog2(N - 1);
    localparam int CW    = $clog2(ITERS + 1);
    localparam int XW    = N - 1 + Q;  // magnitude pre-shifted by Q
    localparam int PRW   = AW + N;     // ln2 product width
    localparam logic [N-1:0] LN2 = N'(32'h0000_B172);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NORM  = 3'd1,
        ITER  = 3'd2,
        SCALE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state;
    logic [N-1:0]        x_reg;
    logic [MW-1:0]       m;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]       i;
    logic [N-1:0]        res_out;
    logic                res_err;

    logic [N-2:0]        mag;
    logic [PW-1:0]       p_idx;
    logic [MW-1:0]       m_init;
    logic signed [AW-1:0] acc_init;
    logic [2*MW-1:0]     sq_full;
    logic [MW-1:0]       m_sq;
    logic signed [AW-1:0] bit_val;
    logic [AW-1:0]       acc_mag;
    logic [PRW-1:0]      prod;
    logic [N-2:0]        res_mag;
    logic                res_neg;

    assign busy = (state != IDLE);
    assign mag  = x_reg[N-2:0];

    // Leading-one position of the latched magnitude.
    always_comb begin
        p_idx = '0;
        for (int b = 0; b < N - 1; b++) begin
            if (mag[b]) p_idx = PW'(b);
        end
    end

    always_comb begin
        // Place the leading one at bit Q so m lies in [1,2).
        m_init   = MW'({mag, {Q{1'b0}}} >> p_idx);
        acc_init = AW'((int'(p_idx) - Q) <<< (Q + G));
        // Square stays below 2^(2Q+2) because m < 2^(Q+1).
        sq_full  = (2*MW)'(m) * (2*MW)'(m);
        m_sq     = MW'(sq_full >> Q);
        bit_val  = AW'(1) <<< (Q + G - int'(i));
    end

    always_comb begin
        acc_mag = acc[AW-1] ? AW'(-acc) : AW'(acc);
`ifdef FIXED_LOG_ROUND_EN
        prod    = PRW'(acc_mag) * PRW'(LN2) + (PRW'(1) << (Q + G - 1));
`else
        prod    = PRW'(acc_mag) * PRW'(LN2);
`endif
        res_mag = (N-1)'(prod >> (Q + G));
        // A result that truncates to zero never carries a minus sign.
        res_neg = acc[AW-1] && (res_mag != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x_reg   <= '0;
            m       <= '0;
            acc     <= '0;
            i       <= '0;
            res_out <= '0;
            res_err <= 1'b0;
            out     <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_reg <= x;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mag == '0) begin
                        res_out <= '1;
                        res_err <= 1'b1;
                        state   <= DONE;
                    end else if (x_reg[N-1]) begin
                        res_out <= '0;
                        res_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        m     <= m_init;
                        acc   <= acc_init;
                        i     <= CW'(1);
                        state <= ITER;
                    end
                end
                ITER: begin
                    // Square >= 2 means the current log2 bit is one.
                    if (m_sq[Q+1]) begin
                        acc <= acc + bit_val;
                        m   <= m_sq >> 1;
                    end else begin
                        m   <= m_sq;
                    end
                    if (i == CW'(ITERS)) state <= SCALE;
                    else                 i     <= i + 1'b1;
                end
                SCALE: begin
                    res_out <= {res_neg, res_mag};
                    res_err <= 1'b0;
                    state   <= DONE;
                end
                DONE: begin
                    out   <= res_out;
                    err   <= res_err;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_log.sv
`timescale 1ns/1ps
module tb_fixed_point_log;

    localparam int FB = 16;
`ifdef FIXED_LOG_ROUND_EN
    localparam int LAT = FB + 4;
`else
    localparam int LAT = FB + 3;
`endif

    // ---------------- clock / reset ----------------
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x     = '0;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        err;

    always #5 clk = ~clk;

    fixed_point_log #(.N(32), .Q(16), .FRAC_BITS(FB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .err   (err)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // ---------------- checkers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic check_near(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp, input int tol);
        int d;
        d = int'(obs) - int'(exp);
        if (d < 0) d = -d;
        chk_cnt++;
        assert ((d <= tol) === 1'b1) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h+-%0d", tag, obs, exp, tol);
    endtask

    // ---------------- driver ----------------
    // Pulses start with operand xv, scrambles x afterwards, waits (bounded)
    // for done. lat is the edge count after the start edge, -1 on timeout.
    task automatic run_op(input logic [31:0] xv, output int lat,
                          output logic [31:0] o, output logic e);
        @(negedge clk);
        x     = xv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x     = $urandom;
        lat   = -1;
        o     = out;
        e     = err;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                o   = out;
                e   = err;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] vec_x   [7];
    logic [31:0] vec_out [7];
    logic        vec_err [7];
    int          vec_lat [7];

    initial begin
        int          lat;
        logic [31:0] o;
        logic        e;
        logic        busy_ok;
        int          n_done;
        int          d0;
        int          d1;

        vec_x[0] = 32'h0002_0000; vec_out[0] = 32'h0000_B172; vec_err[0] = 1'b0; vec_lat[0] = LAT;
        vec_x[1] = 32'h0004_0000; vec_out[1] = 32'h0001_62E4; vec_err[1] = 1'b0; vec_lat[1] = LAT;
        vec_x[2] = 32'h0000_8000; vec_out[2] = 32'h8000_B172; vec_err[2] = 1'b0; vec_lat[2] = LAT;
        vec_x[3] = 32'h0000_0000; vec_out[3] = 32'hFFFF_FFFF; vec_err[3] = 1'b1; vec_lat[3] = 2;
        vec_x[4] = 32'h8000_0000; vec_out[4] = 32'hFFFF_FFFF; vec_err[4] = 1'b1; vec_lat[4] = 2;
        vec_x[5] = 32'h8001_0000; vec_out[5] = 32'h0000_0000; vec_err[5] = 1'b1; vec_lat[5] = 2;
        vec_x[6] = 32'h0001_0000; vec_out[6] = 32'h0000_0000; vec_err[6] = 1'b0; vec_lat[6] = LAT;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_out",  out,           32'd0);
        check("rst_err",  {31'b0, err},  32'd0);
        rst_n = 1'b1;

        // ln(1.0) with busy tracking
        @(negedge clk);
        x     = 32'h0001_0000;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        busy_ok = 1'b1;
        lat     = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        check("one_lat",      32'(lat),          32'(LAT));
        check("one_out",      out,               32'h0000_0000);
        check("one_err",      {31'b0, err},      32'd0);
        check("one_busy_run", {31'b0, busy_ok},  32'd1);
        check("one_busy_end", {31'b0, busy},     32'd0);
        @(negedge clk);
        check("one_done_pulse", {31'b0, done},   32'd0);

        // Directed table: exact results and domain errors
        for (int v = 0; v < 7; v++) begin
            run_op(vec_x[v], lat, o, e);
            check($sformatf("vec%0d_lat", v), 32'(lat),      32'(vec_lat[v]));
            check($sformatf("vec%0d_out", v), o,             vec_out[v]);
            check($sformatf("vec%0d_err", v), {31'b0, e},    {31'b0, vec_err[v]});
        end

        // ln(e) ~ 1.0
        run_op(32'h0002_B7E1, lat, o, e);
        check("e_lat", 32'(lat), 32'(LAT));
        check_near("e_out", o, 32'h0001_0000, 4);
        // ln(2^-16) ~ -11.09
        run_op(32'h0000_0001, lat, o, e);
        check("tiny_lat", 32'(lat), 32'(LAT));
        check("tiny_sign", {31'b0, o[31]}, 32'd1);
        check_near("tiny_mag", {1'b0, o[30:0]}, 32'h000B_1721, 8);
        check("tiny_err", {31'b0, e}, 32'd0);

        // start while busy is ignored
        @(negedge clk);
        x     = 32'h0002_0000;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        d0     = -1;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (d0 < 0) d0 = k;
                o = out;
            end
        end
        check("busy_start_count", 32'(n_done), 32'd1);
        check("busy_start_lat",   32'(d0),     32'(LAT));
        check("busy_start_out",   o,           32'h0000_B172);

        // start held high: back-to-back operations
        @(negedge clk);
        x     = 32'h0004_0000;
        start = 1'b1;
        @(negedge clk);
        n_done = 0;
        d0     = -1;
        d1     = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 25) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (d0 < 0) d0 = k;
                else        d1 = k;
                o = out;
            end
        end
        check("b2b_count", 32'(n_done),  32'd2);
        check("b2b_first", 32'(d0),      32'(LAT));
        check("b2b_gap",   32'(d1 - d0), 32'(LAT + 1));
        check("b2b_out",   o,            32'h0001_62E4);

        // Reset mid-operation
        @(negedge clk);
        x     = 32'h0002_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_out",  out,           32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        run_op(32'h0002_0000, lat, o, e);
        check("after_abort_lat", 32'(lat),   32'(LAT));
        check("after_abort_out", o,          32'h0000_B172);
        check("after_abort_err", {31'b0, e}, 32'd0);

        // Report
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
